apb_weight_loader: RTL and testbench

APB master sequencer that programs the filter's eight 10-bit weight registers into the APB weight register file. It takes a packed 80-bit weight vector from the control path on a start pulse and serializes it into DATA_WIDTH-wide APB write transfers. It can optionally read every word back and compare it against the written value. It sits between the host/control logic and the weight register file's APB completer port, and is the only APB requester on that port.

---
 rtl/apb_weight_loader.sv | 119 +++++++++++
 tb/tb_apb_weight_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_weight_loader.sv
// apb_weight_loader: serializes an 80-bit weight vector into APB write transfers,
// with an optional readback/compare pass and a per-transfer PREADY timeout.
module apb_weight_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic                  i_verify,
  input  logic [79:0]           i_weights,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_err,
  output logic [3:0]            o_err_idx,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA
);
  localparam int NUM_WORDS = (80 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PW = NUM_WORDS * DATA_WIDTH;
  localparam logic [3:0] LAST = 4'(NUM_WORDS - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS, DONE} state_t;
  state_t state, nxt;
  logic [PW-1:0] snap, src;
  logic verify;
  logic [3:0] k, k_n, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] err_n;
  logic [DATA_WIDTH-1:0] word_k, word_n;
  // In IDLE the outgoing first word must come straight from the input being captured
  assign src = (state == IDLE) ? PW'(i_weights) : snap;
  assign word_k = snap[k * DATA_WIDTH +: DATA_WIDTH];
  assign word_n = src[k_n * DATA_WIDTH +: DATA_WIDTH];
  always_comb begin
    nxt = state;
    k_n = k;
    cnt_n = cnt;
    err_n = o_err;
    idx_n = o_err_idx;
    case (state)
      IDLE: if (i_start) begin
        nxt = W_SETUP;
        k_n = '0;
        err_n = '0;
        idx_n = '0;
      end
      W_SETUP: begin
        nxt = W_ACCESS;
        cnt_n = '0;
      end
      R_SETUP: begin
        nxt = R_ACCESS;
        cnt_n = '0;
      end
      W_ACCESS, R_ACCESS:
        if (i_PREADY) begin
          if (state == R_ACCESS && i_PRDATA != word_k && o_err == 2'b00) begin
            err_n = 2'b01;
            idx_n = k;
          end
          if (k != LAST) begin
            k_n = k + 4'd1;
            nxt = (state == W_ACCESS) ? W_SETUP : R_SETUP;
          end else if (state == W_ACCESS && verify) begin
            k_n = '0;
            nxt = R_SETUP;
          end else nxt = DONE;
        end else if (cnt == TO_LAST) begin
          err_n = 2'b10;
          idx_n = k;
          nxt = DONE;
        end else cnt_n = cnt + 8'd1;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
      snap <= '0;
      verify <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= '0;
      o_err_idx <= '0;
      o_PADDR <= '0;
      o_PSEL <= 1'b0;
      o_PENABLE <= 1'b0;
      o_PWRITE <= 1'b0;
      o_PWDATA <= '0;
    end else begin
      state <= nxt;
      k <= k_n;
      cnt <= cnt_n;
      o_err <= err_n;
      o_err_idx <= idx_n;
      if (state == IDLE && i_start) begin
        snap <= src;
        verify <= i_verify;
      end
      o_busy <= nxt != IDLE;
      o_done <= nxt == DONE;
      o_PSEL <= nxt inside {W_SETUP, W_ACCESS, R_SETUP, R_ACCESS};
      o_PENABLE <= nxt inside {W_ACCESS, R_ACCESS};
      o_PWRITE <= nxt inside {W_SETUP, W_ACCESS};
      o_PADDR <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(k_n);
      o_PWDATA <= (nxt inside {W_SETUP, W_ACCESS}) ? word_n : '0;
    end
endmodule

// File: tb/tb_apb_weight_loader.sv
// tb_apb_weight_loader: table-driven check of the 8-bit loader plus a 32-bit
// instance under random wait states and a mid-transfer reset sequence.
module tb_apb_weight_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  logic start, verify, busy, done, psel, penable, pwrite, pready;
  logic [79:0] weights;
  logic [1:0] err;
  logic [3:0] err_idx;
  logic [9:0] paddr;
  logic [7:0] pwdata, prdata;
  apb_weight_loader #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .i_start(start), .i_verify(verify), .i_weights(weights),
    .o_busy(busy), .o_done(done), .o_err(err), .o_err_idx(err_idx),
    .o_PADDR(paddr), .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite),
    .o_PWDATA(pwdata), .i_PREADY(pready), .i_PRDATA(prdata));
  logic start32, busy32, done32, psel32, penable32, pwrite32;
  logic pready32 = 1'b0;
  logic [79:0] weights32;
  logic [1:0] err32;
  logic [3:0] err_idx32;
  logic [9:0] paddr32;
  logic [31:0] pwdata32, prdata32;
  apb_weight_loader #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rstn(rstn), .i_start(start32), .i_verify(1'b1), .i_weights(weights32),
    .o_busy(busy32), .o_done(done32), .o_err(err32), .o_err_idx(err_idx32),
    .o_PADDR(paddr32), .o_PSEL(psel32), .o_PENABLE(penable32), .o_PWRITE(pwrite32),
    .o_PWDATA(pwdata32), .i_PREADY(pready32), .i_PRDATA(prdata32));

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 8-bit completer: memory, selectable stall word, per-word readback corruption
  logic [7:0] mem8 [16];
  int stall_word;
  logic stall_rd, clr8;
  logic [15:0] corrupt;
  int wr_cnt, rd_cnt, stall_run, max_stall, proto8;
  logic [9:0] s_addr;
  logic [7:0] s_data;
  logic s_write;
  assign pready = !(psel && int'(paddr) == stall_word && (!stall_rd || !pwrite));
  assign prdata = mem8[paddr[3:0]] ^ (corrupt[paddr[3:0]] ? 8'h01 : 8'h00);
  always @(negedge clk) begin
    if (clr8) begin
      wr_cnt = 0; rd_cnt = 0; stall_run = 0; max_stall = 0; proto8 = 0;
      for (int i = 0; i < 16; i++) mem8[i] = 8'hEE;
    end else if (rstn) begin
      if (penable && !psel) proto8++;
      if (psel && !penable) begin
        s_addr = paddr; s_data = pwdata; s_write = pwrite; stall_run = 0;
      end
      if (psel && penable) begin
        if (paddr !== s_addr || pwdata !== s_data || pwrite !== s_write) proto8++;
        if (!pwrite && pwdata !== 8'h00) proto8++;
        if (pready) begin
          if (pwrite) begin mem8[paddr[3:0]] = pwdata; wr_cnt++; end
          else rd_cnt++;
        end else begin
          stall_run++;
          if (stall_run > max_stall) max_stall = stall_run;
        end
      end
    end
  end

  // 32-bit completer with 0..3 random wait states per transfer
  logic [31:0] mem32 [4];
  logic clr32, s32_w;
  logic [9:0] s32_addr;
  logic [31:0] s32_data;
  int waits32, wc, wt, proto32, wr32, rd32;
  assign prdata32 = mem32[paddr32[1:0]];
  always @(negedge clk) begin
    if (clr32) begin
      waits32 = 0; wc = 0; wt = $urandom_range(0, 3); proto32 = 0; wr32 = 0; rd32 = 0;
      for (int i = 0; i < 4; i++) mem32[i] = 32'h0;
      pready32 = 1'b0;
    end else begin
      pready32 = 1'b0;
      if (psel32 && !penable32) begin s32_addr = paddr32; s32_data = pwdata32; s32_w = pwrite32; end
      if (psel32 && penable32) begin
        if (paddr32 !== s32_addr || pwdata32 !== s32_data || pwrite32 !== s32_w) proto32++;
        if (wc == wt) begin
          pready32 = 1'b1;
          if (pwrite32) begin mem32[paddr32[1:0]] = pwdata32; wr32++; end
          else rd32++;
          wc = 0; wt = $urandom_range(0, 3);
        end else begin
          wc++; waits32++;
        end
      end
    end
  end

  typedef struct {
    logic [79:0] w;
    logic ver;
    int stall;
    logic srd;
    logic [15:0] cor;
    int poke;
    int exp_done;
    logic [1:0] exp_err;
    logic [3:0] exp_idx;
    int exp_wr, exp_rd, exp_stall;
  } vec_t;
  localparam logic [79:0] WA = {10'h0FF, 10'h100, 10'h3FF, 10'h000, 10'h2AA, 10'h155, 10'h001, 10'h3FF};
  localparam logic [79:0] WB = 80'h1234_5678_9ABC_DEF0_0F1E;
  vec_t vecs [7];

  task automatic apply8(input vec_t v, input string nm);
    int dcyc, busy_bad, late;
    clr8 = 1'b1;
    @(negedge clk);
    #1 clr8 = 1'b0;
    weights = v.w; verify = v.ver; stall_word = v.stall; stall_rd = v.srd; corrupt = v.cor;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcyc = 0; busy_bad = 0; late = 0;
    for (int c = 1; c <= 200 && dcyc == 0; c++) begin
      @(negedge clk);
      if (c == v.poke) begin start = 1'b1; weights = ~v.w; end
      else if (c == v.poke + 1) begin start = 1'b0; weights = v.w; end
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) dcyc = c;
    end
    start = 1'b0;
    weights = v.w;
    check({nm, " done_cycle"}, dcyc, v.exp_done);
    check({nm, " busy_window"}, busy_bad, 0);
    @(negedge clk);
    check({nm, " idle_after"}, {busy, done, psel, penable}, 4'b0);
    check({nm, " err"}, err, v.exp_err);
    check({nm, " err_idx"}, err_idx, v.exp_idx);
    check({nm, " writes"}, wr_cnt, v.exp_wr);
    check({nm, " reads"}, rd_cnt, v.exp_rd);
    check({nm, " stall_cycles"}, max_stall, v.exp_stall);
    check({nm, " protocol"}, proto8, 0);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s mem[%0d]", nm, i), mem8[i], (i < v.exp_wr) ? v.w[i*8 +: 8] : 8'hEE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) late++;
    end
    check({nm, " no_restart"}, late, 0);
  endtask

  task automatic apply32(input logic [79:0] w, input string nm);
    int dcyc;
    logic [95:0] pad;
    pad = {16'h0, w};
    clr32 = 1'b1;
    @(negedge clk);
    #1 clr32 = 1'b0;
    weights32 = w;
    start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    dcyc = 0;
    for (int c = 1; c <= 300 && dcyc == 0; c++) begin
      @(negedge clk);
      if (done32 === 1'b1) dcyc = c;
    end
    check({nm, " done_cycle"}, dcyc, 13 + waits32);
    check({nm, " err"}, err32, 2'b00);
    check({nm, " writes"}, wr32, 3);
    check({nm, " reads"}, rd32, 3);
    check({nm, " protocol"}, proto32, 0);
    check({nm, " word2_pad"}, {16'h0, mem32[2][31:16]}, 32'h0);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s mem[%0d]", nm, i), mem32[i], pad[i*32 +: 32]);
  endtask

  initial begin
    int found, bad;
    vecs[0] = '{WA, 1'b0, -1, 1'b0, 16'h0000, 0, 21, 2'b00, 4'd0, 10, 0, 0};
    vecs[1] = '{WA, 1'b1, -1, 1'b0, 16'h0000, 0, 41, 2'b00, 4'd0, 10, 10, 0};
    vecs[2] = '{WA, 1'b1, -1, 1'b0, 16'h0088, 0, 41, 2'b01, 4'd3, 10, 10, 0};
    vecs[3] = '{WA, 1'b0, 5, 1'b0, 16'h0000, 0, 28, 2'b10, 4'd5, 5, 0, 16};
    vecs[4] = '{WB, 1'b1, -1, 1'b0, 16'h0200, 0, 41, 2'b01, 4'd9, 10, 10, 0};
    vecs[5] = '{WB, 1'b1, 6, 1'b1, 16'h0008, 0, 50, 2'b10, 4'd6, 10, 6, 16};
    vecs[6] = '{WB, 1'b0, -1, 1'b0, 16'h0000, 5, 21, 2'b00, 4'd0, 10, 0, 0};
    rstn = 1'b0; start = 1'b0; verify = 1'b0; weights = '0; stall_word = -1; stall_rd = 1'b0;
    corrupt = '0; clr8 = 1'b0; start32 = 1'b0; weights32 = '0; clr32 = 1'b0;
    #1;
    check("reset8", {busy, done, psel, penable, pwrite, err, err_idx, paddr, pwdata}, 32'h0);
    check("reset32", {busy32, done32, psel32, penable32, pwrite32, err32, err_idx32, paddr32}, 32'h0);
    check("reset32_wdata", pwdata32, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) apply8(vecs[i], $sformatf("vec%0d", i));
    apply32(80'h0123_4567_89AB_CDEF_FEDC, "w32a");
    apply32({80{1'b1}}, "w32b");
    clr8 = 1'b1;
    @(negedge clk);
    #1 clr8 = 1'b0;
    weights = WA; verify = 1'b0; stall_word = -1; corrupt = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (psel && penable && paddr == 10'd2) found = 1;
    end
    check("rst_reach_word2", found, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_bus", {psel, penable, busy, done}, 4'b0);
    @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || psel !== 1'b0) bad++;
    end
    check("rst_no_done", bad, 0);
    apply8(vecs[0], "after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
